bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 16-bit-address system bus. The CPU is master 0; a second requester (DMA or debug loader) is master 1.
- Sits between the masters and the address decoder/peripheral fabric. It serialises accesses with round-robin priority and holds the slave bus stable for a whole transaction.
- Guarantees forward progress with a read timeout that returns an error word and sets a sticky error flag.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_arb2.sv | 13 +
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared state/op encodings and defaults for the two-master system-bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: the requester that did not win last time
// takes a tie; no latency, no backpressure.
module bus_arbiter_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  assign gnt_valid_o = |req_i;
  assign gnt_idx_o   = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/bus_arbiter.sv
// Two-master/one-slave bus arbiter: write completes in 2 cycles, read in 2 + slave latency;
// masters hold requests until completion, and a silent slave is cut off after TIMEOUT cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int          W        = 32,
  parameter int          AW       = 16,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic          m0_ren,
  input  logic          m1_ren,
  input  logic          m0_wen,
  input  logic          m1_wen,
  input  logic [W-1:0]  m0_wdata,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m0_wr_mask,
  input  logic [3:0]    m1_wr_mask,
  output logic [W-1:0]  m0_rdata,
  output logic [W-1:0]  m1_rdata,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic          m0_wr_done,
  output logic          m1_wr_done,
  output logic [AW-1:0] s_addr,
  output logic          s_ren,
  output logic          s_wen,
  output logic [W-1:0]  s_wdata,
  output logic [3:0]    s_wr_mask,
  input  logic [W-1:0]  s_rdata,
  input  logic          s_rd_valid,
  output logic          err,
  output logic          busy
);

  localparam int             CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [W-1:0]   ERR_W = W'(ERR_DATA);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic gnt_valid, gnt_idx;
  logic rd_phase, timeout_hit, rd_done;

  bus_arbiter_rr_arb2 u_rr (
    .req_i       ({m1_ren | m1_wen, m0_ren | m0_wen}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign rd_phase    = (state_q == ST_ISSUE && op_q == OP_READ) || state_q == ST_WAIT;
  // Slave data arriving on the timeout cycle takes precedence over the error word.
  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == TMO) && !s_rd_valid;
  assign rd_done     = rd_phase && (s_rd_valid || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          op_d    = (gnt_idx ? m1_wen : m0_wen) ? OP_WRITE : OP_READ;
          addr_d  = gnt_idx ? m1_addr : m0_addr;
          wdata_d = gnt_idx ? m1_wdata : m0_wdata;
          mask_d  = gnt_idx ? m1_wr_mask : m0_wr_mask;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_WRITE || s_rd_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (rd_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = err_q | timeout_hit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ren       = (state_q == ST_ISSUE) && (op_q == OP_READ);
    s_wen       = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
    m0_wr_done  = s_wen && !owner_q;
    m1_wr_done  = s_wen && owner_q;
    m0_rd_valid = rd_done && !owner_q;
    m1_rd_valid = rd_done && owner_q;
    m0_rdata    = '0;
    m1_rdata    = '0;
    if (rd_phase) begin
      if (owner_q) m1_rdata = timeout_hit ? ERR_W : s_rdata;
      else         m0_rdata = timeout_hit ? ERR_W : s_rdata;
    end
  end

  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wr_mask = mask_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table, hand-written corner sequences, then random traffic against a transaction-level model.
module tb_bus_arbiter;
  localparam int          W   = 32;
  localparam int          AW  = 16;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic m0_ren, m1_ren, m0_wen, m1_wen;
  logic [W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0] m0_wr_mask, m1_wr_mask, s_wr_mask;
  logic m0_rd_valid, m1_rd_valid, m0_wr_done, m1_wr_done;
  logic s_ren, s_wen, s_rd_valid, err, busy;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.W(W), .AW(AW), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_ren(m0_ren), .m1_ren(m1_ren),
    .m0_wen(m0_wen), .m1_wen(m1_wen), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wr_mask(m0_wr_mask), .m1_wr_mask(m1_wr_mask), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid), .m0_wr_done(m0_wr_done), .m1_wr_done(m1_wr_done),
    .s_addr(s_addr), .s_ren(s_ren), .s_wen(s_wen), .s_wdata(s_wdata), .s_wr_mask(s_wr_mask),
    .s_rdata(s_rdata), .s_rd_valid(s_rd_valid), .err(err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // {busy, s_ren, s_wen, m0_rd_valid, m1_rd_valid, m0_wr_done, m1_wr_done, err}
  function automatic logic [7:0] ctl();
    return {busy, s_ren, s_wen, m0_rd_valid, m1_rd_valid, m0_wr_done, m1_wr_done, err};
  endfunction

  typedef struct {
    logic r0, w0, r1, w1, srv;
    logic [7:0]  ex;
    logic [15:0] ea;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [4:0] in, input logic [7:0] ex, input logic [15:0] ea);
    vec_t v;
    {v.r0, v.w0, v.r1, v.w1, v.srv} = in;
    v.ex = ex;
    v.ea = ea;
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Transaction-level reference: elapsed cycles since grant, not a state encoding.
  bit m_act, m_own, m_w, m_last, m_err;
  int m_k;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_mk;

  logic        mr[2], mw[2];
  logic [15:0] ma[2];
  logic [31:0] md[2];
  logic [3:0]  mm[2];
  bit          done_seen[2];

  task automatic new_req(input int j);
    int op;
    op = $urandom_range(0, 2);
    mr[j] = (op != 1);
    mw[j] = (op != 0);
    ma[j] = 16'($urandom);
    md[j] = $urandom;
    mm[j] = 4'($urandom);
  endtask

  initial begin
    int t_ren, t_rv, cd, lat;
    logic [31:0] rd_cap, e_r0, e_r1, rdv;
    logic [7:0] e_ctl;
    bit rd, tmo, rcomp, wcomp, r0, r1;

    m0_addr = 16'h0010; m1_addr = 16'h4000;
    m0_wdata = 32'h11112222; m1_wdata = 32'h0000005A;
    m0_wr_mask = 4'hF; m1_wr_mask = 4'b0001;
    {m0_ren, m0_wen, m1_ren, m1_wen, s_rd_valid} = '0;
    s_rdata = 32'h12345678;

    tbl[0]  = mk(5'b10000, 8'h00, 16'h0000);
    tbl[1]  = mk(5'b10000, 8'hC0, 16'h0010);
    tbl[2]  = mk(5'b10001, 8'h90, 16'h0010);
    tbl[3]  = mk(5'b00000, 8'h00, 16'h0010);
    tbl[4]  = mk(5'b00010, 8'h00, 16'h0010);
    tbl[5]  = mk(5'b00010, 8'hA2, 16'h4000);
    tbl[6]  = mk(5'b00000, 8'h00, 16'h4000);
    tbl[7]  = mk(5'b10100, 8'h00, 16'h4000);
    tbl[8]  = mk(5'b10100, 8'hC0, 16'h0010);
    tbl[9]  = mk(5'b10101, 8'h90, 16'h0010);
    tbl[10] = mk(5'b10100, 8'h00, 16'h0010);
    tbl[11] = mk(5'b10100, 8'hC0, 16'h4000);
    tbl[12] = mk(5'b10101, 8'h88, 16'h4000);
    tbl[13] = mk(5'b10100, 8'h00, 16'h4000);
    tbl[14] = mk(5'b10100, 8'hC0, 16'h0010);
    tbl[15] = mk(5'b10101, 8'h90, 16'h0010);
    tbl[16] = mk(5'b10100, 8'h00, 16'h0010);
    tbl[17] = mk(5'b10100, 8'hC0, 16'h4000);
    tbl[18] = mk(5'b10101, 8'h88, 16'h4000);
    tbl[19] = mk(5'b00000, 8'h00, 16'h4000);
    tbl[20] = mk(5'b10000, 8'h00, 16'h4000);
    tbl[21] = mk(5'b10001, 8'hD0, 16'h0010);
    tbl[22] = mk(5'b00010, 8'h00, 16'h0010);
    tbl[23] = mk(5'b00010, 8'hA2, 16'h4000);
    tbl[24] = mk(5'b00001, 8'h00, 16'h4000);
    tbl[25] = mk(5'b11000, 8'h00, 16'h4000);
    tbl[26] = mk(5'b11000, 8'hA4, 16'h0010);
    tbl[27] = mk(5'b00000, 8'h00, 16'h0010);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", ctl(), 8'h00);
    chk("reset_saddr", s_addr, 16'h0000);
    chk("reset_swdata", {s_wdata, s_wr_mask}, 36'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      {m0_ren, m0_wen, m1_ren, m1_wen, s_rd_valid} =
        {tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].srv};
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(), tbl[i].ex);
      chk($sformatf("vec%0d_saddr", i), s_addr, tbl[i].ea);
      if (tbl[i].ex[4]) chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, 32'h12345678);
      if (tbl[i].ex[3]) chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, 32'h12345678);
      if (tbl[i].ex[5])
        chk($sformatf("vec%0d_swdata", i), {s_wdata, s_wr_mask},
            (tbl[i].ea == 16'h4000) ? {32'h0000005A, 4'b0001} : {32'h11112222, 4'hF});
    end

    // Silent slave: error word TMO cycles after s_ren, sticky err.
    t_ren = -1; t_rv = -1; rd_cap = '0;
    @(negedge clk);
    {m0_ren, m0_wen, m1_ren, m1_wen, s_rd_valid} = 5'b10000;
    for (int n = 0; n < 30 && t_rv < 0; n++) begin
      #1;
      if (s_ren && t_ren < 0) t_ren = n;
      if (m0_rd_valid) begin t_rv = n; rd_cap = m0_rdata; end
      @(negedge clk);
    end
    m0_ren = 1'b0;
    #1;
    chk("timeout_seen", (t_rv >= 0 && t_ren >= 0), 1'b1);
    chk("timeout_latency", t_rv - t_ren, TMO);
    chk("timeout_rdata", rd_cap, ERR);
    chk("timeout_err", err, 1'b1);
    @(negedge clk) m0_ren = 1'b1;
    @(negedge clk);
    @(negedge clk) begin s_rd_valid = 1'b1; s_rdata = 32'hCAFEF00D; end
    #1;
    chk("good_after_tmo_ctl", ctl(), 8'h91);
    chk("good_after_tmo_rdata", m0_rdata, 32'hCAFEF00D);
    @(negedge clk) begin m0_ren = 1'b0; s_rd_valid = 1'b0; end
    #1 chk("err_sticky", ctl(), 8'h01);

    // Asynchronous reset while waiting on the slave.
    @(negedge clk) m1_ren = 1'b1;
    @(negedge clk);
    #1 chk("rst_issue", ctl(), 8'hC1);
    @(negedge clk);
    #1 chk("rst_wait", ctl(), 8'h81);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", ctl(), 8'h00);
    chk("rst_async_saddr", s_addr, 16'h0000);
    @(negedge clk);
    #1 chk("rst_held_ctl", ctl(), 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_regrant_ctl", ctl(), 8'hC0);
    chk("rst_regrant_saddr", s_addr, 16'h4000);
    @(negedge clk) s_rd_valid = 1'b1;
    #1 chk("rst_regrant_done", ctl(), 8'h88);
    @(negedge clk) begin m1_ren = 1'b0; s_rd_valid = 1'b0; end

    // Random traffic against the reference model.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_act = 0; m_own = 0; m_w = 0; m_last = 1; m_err = 0; m_k = 0;
    m_addr = '0; m_wd = '0; m_mk = '0;
    for (int j = 0; j < 2; j++) begin
      mr[j] = 0; mw[j] = 0; ma[j] = '0; md[j] = '0; mm[j] = '0; done_seen[j] = 0;
    end
    cd = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (done_seen[j]) begin
          mr[j] = 0; mw[j] = 0;
          if ($urandom_range(0, 1) == 0) new_req(j);
        end else if (!mr[j] && !mw[j] && $urandom_range(0, 2) == 0) begin
          new_req(j);
        end
      end
      {m0_ren, m0_wen, m0_addr, m0_wdata, m0_wr_mask} = {mr[0], mw[0], ma[0], md[0], mm[0]};
      {m1_ren, m1_wen, m1_addr, m1_wdata, m1_wr_mask} = {mr[1], mw[1], ma[1], md[1], mm[1]};
      s_rdata = $urandom;
      s_rd_valid = 1'b0;
      if (s_ren) begin
        lat = $urandom_range(0, 10);
        if (lat == 0) s_rd_valid = 1'b1;
        cd = lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) s_rd_valid = 1'b1;
      end else begin
        s_rd_valid = ($urandom_range(0, 9) == 0);
      end
      #1;
      rd    = m_act && !m_w;
      tmo   = rd && (m_k == TMO) && !s_rd_valid;
      rcomp = rd && (s_rd_valid || m_k == TMO);
      wcomp = m_act && m_w && (m_k == 0);
      e_ctl = {m_act, m_act && m_k == 0 && !m_w, m_act && m_k == 0 && m_w,
               rcomp && !m_own, rcomp && m_own, wcomp && !m_own, wcomp && m_own, m_err};
      rdv  = tmo ? ERR : s_rdata;
      e_r0 = (rd && !m_own) ? rdv : 32'h0;
      e_r1 = (rd && m_own) ? rdv : 32'h0;
      chk($sformatf("rnd%0d_ctl", c), ctl(), e_ctl);
      chk($sformatf("rnd%0d_saddr", c), s_addr, m_addr);
      chk($sformatf("rnd%0d_swdata", c), {s_wdata, s_wr_mask}, {m_wd, m_mk});
      chk($sformatf("rnd%0d_m0_rdata", c), m0_rdata, e_r0);
      chk($sformatf("rnd%0d_m1_rdata", c), m1_rdata, e_r1);
      done_seen[0] = e_ctl[4] || e_ctl[2];
      done_seen[1] = e_ctl[3] || e_ctl[1];
      if (m_act) begin
        if (tmo) m_err = 1;
        if (rcomp || wcomp) m_act = 0;
        else m_k++;
      end else begin
        r0 = m0_ren || m0_wen;
        r1 = m1_ren || m1_wen;
        if (r0 || r1) begin
          m_own  = (r0 && r1) ? !m_last : r1;
          m_last = m_own;
          m_act  = 1;
          m_k    = 0;
          m_w    = m_own ? m1_wen : m0_wen;
          m_addr = m_own ? m1_addr : m0_addr;
          m_wd   = m_own ? m1_wdata : m0_wdata;
          m_mk   = m_own ? m1_wr_mask : m0_wr_mask;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
